// File: rtl/pulse_seq_pkg.sv
// Purpose: shared state encoding and phase codes for the pulse sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pulse_seq_pkg;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_DELAY = 3'd1;
    localparam logic [2:0] PH_RISE  = 3'd2;
    localparam logic [2:0] PH_HIGH  = 3'd3;
    localparam logic [2:0] PH_FALL  = 3'd4;
    localparam logic [2:0] PH_LOW   = 3'd5;

    // The state code doubles as the externally visible phase code.
    typedef enum logic [2:0] {
        ST_IDLE  = PH_IDLE,
        ST_DELAY = PH_DELAY,
        ST_RISE  = PH_RISE,
        ST_HIGH  = PH_HIGH,
        ST_FALL  = PH_FALL,
        ST_LOW   = PH_LOW
    } state_t;

endpackage

// File: rtl/pulse_seq_ctrl_if.sv
// Purpose: control/config/status bundle between a host and the pulse sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start is a level sampled in IDLE, stop aborts at the next edge.
interface pulse_seq_ctrl_if #(
    parameter int AW = 16,
    parameter int TW = 16
);
    logic          start;
    logic          stop;
    logic [AW-1:0] iv;
    logic [AW-1:0] pv;
    logic [AW-1:0] rise_step;
    logic [AW-1:0] fall_step;
    logic [TW-1:0] t_delay;
    logic [TW-1:0] t_high;
    logic [TW-1:0] t_low;
    logic [AW-1:0] level;
    logic [2:0]    phase;
    logic          busy;
    logic          done;

    modport master (
        output start, stop, iv, pv, rise_step, fall_step, t_delay, t_high, t_low,
        input  level, phase, busy, done
    );

    modport slave (
        input  start, stop, iv, pv, rise_step, fall_step, t_delay, t_high, t_low,
        output level, phase, busy, done
    );
endinterface

// File: rtl/pulse_ramp.sv
// Purpose: one saturating ramp step of level toward target (up or down); step 0 jumps to target.
// Latency: combinational.
// Backpressure: n/a.
module pulse_ramp #(
    parameter int AW = 16
) (
    input  logic          up,
    input  logic [AW-1:0] level,
    input  logic [AW-1:0] step,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] nxt,
    output logic          hit
);
    logic [AW:0] sum;
    logic [AW:0] lo_lim;

    // Sums carry one extra bit so a large step saturates instead of wrapping.
    always_comb begin
        sum    = {1'b0, level} + {1'b0, step};
        lo_lim = {1'b0, target} + {1'b0, step};
        nxt    = target;
        if (up) begin
            if ((step != '0) && (sum < {1'b0, target})) begin
                nxt = sum[AW-1:0];
            end
        end else begin
            if ((step != '0) && ({1'b0, level} > lo_lim)) begin
                nxt = level - step;
            end
        end
        hit = (nxt == target);
    end
endmodule

// File: rtl/pulse_seq_ctrl.sv
// Purpose: delay/rise/high/fall(/low) pulse sequencer; PULSE_SEQ_REPEAT_EN makes it free-run through LOW.
// Latency: start sampled in IDLE -> DELAY/RISE on that edge; all outputs registered.
// Backpressure: start ignored while busy; stop aborts to IDLE on the next edge and wins over start.
module pulse_seq_ctrl
    import pulse_seq_pkg::*;
#(
    parameter int AW = 16,
    parameter int TW = 16
) (
    input  logic            clk,
    input  logic            rst,
    pulse_seq_ctrl_if.slave bus
);
    state_t        state_q, state_d;
    logic [AW-1:0] level_q, level_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          busy_q, done_q, done_d;
    logic          load_cfg;

    logic [AW-1:0] iv_q, pv_q, rs_q, fs_q;
    logic [TW-1:0] th_q;
`ifdef PULSE_SEQ_REPEAT_EN
    logic [TW-1:0] tl_q;
`endif

    logic          ramp_up;
    logic [AW-1:0] ramp_nxt;
    logic          ramp_hit;

    assign ramp_up = (state_q == ST_RISE);

    pulse_ramp #(.AW(AW)) u_ramp (
        .up     (ramp_up),
        .level  (level_q),
        .step   (ramp_up ? rs_q : fs_q),
        .target (ramp_up ? pv_q : iv_q),
        .nxt    (ramp_nxt),
        .hit    (ramp_hit)
    );

    // Next-state logic; the shared down-counter is loaded with N-1 so a phase lasts exactly N cycles.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        load_cfg = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    load_cfg = 1'b1;
                    level_d  = bus.iv;
                    if (bus.t_delay != '0) begin
                        state_d = ST_DELAY;
                        cnt_d   = bus.t_delay - TW'(1);
                    end else begin
                        state_d = ST_RISE;
                    end
                end
            end
            ST_DELAY: begin
                if (cnt_q == '0) state_d = ST_RISE;
                else             cnt_d   = cnt_q - TW'(1);
            end
            ST_RISE: begin
                level_d = ramp_nxt;
                if (ramp_hit) begin
                    if (th_q != '0) begin
                        state_d = ST_HIGH;
                        cnt_d   = th_q - TW'(1);
                    end else begin
                        state_d = ST_FALL;
                    end
                end
            end
            ST_HIGH: begin
                if (cnt_q == '0) state_d = ST_FALL;
                else             cnt_d   = cnt_q - TW'(1);
            end
            ST_FALL: begin
                level_d = ramp_nxt;
                if (ramp_hit) begin
`ifdef PULSE_SEQ_REPEAT_EN
                    if (tl_q != '0) begin
                        state_d = ST_LOW;
                        cnt_d   = tl_q - TW'(1);
                    end else begin
                        state_d = ST_RISE;
                    end
`else
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
            ST_LOW: begin
`ifdef PULSE_SEQ_REPEAT_EN
                if (cnt_q == '0) state_d = ST_RISE;
                else             cnt_d   = cnt_q - TW'(1);
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort from any busy state: back to the initial level, no completion pulse.
        if ((state_q != ST_IDLE) && bus.stop) begin
            state_d = ST_IDLE;
            level_d = iv_q;
            done_d  = 1'b0;
        end
    end

    // State, level, counter and latched configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            iv_q    <= '0;
            pv_q    <= '0;
            rs_q    <= '0;
            fs_q    <= '0;
            th_q    <= '0;
`ifdef PULSE_SEQ_REPEAT_EN
            tl_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= done_d;
            if (load_cfg) begin
                iv_q <= bus.iv;
                pv_q <= bus.pv;
                rs_q <= bus.rise_step;
                fs_q <= bus.fall_step;
                th_q <= bus.t_high;
`ifdef PULSE_SEQ_REPEAT_EN
                tl_q <= bus.t_low;
`endif
            end
        end
    end

    assign bus.level = level_q;
    assign bus.phase = state_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Purpose: directed self-checking bench for pulse_seq_ctrl (16-bit and 8-bit instances).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_pulse_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pulse_seq_ctrl_if #(.AW(16), .TW(16)) bus ();
    pulse_seq_ctrl_if #(.AW(8),  .TW(8))  bus8 ();

    pulse_seq_ctrl #(.AW(16), .TW(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    pulse_seq_ctrl #(.AW(8),  .TW(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] iv, input logic [15:0] pv,
                           input logic [15:0] rs, input logic [15:0] fs,
                           input logic [15:0] td, input logic [15:0] th,
                           input logic [15:0] tl);
        bus.iv        = iv;
        bus.pv        = pv;
        bus.rise_step = rs;
        bus.fall_step = fs;
        bus.t_delay   = td;
        bus.t_high    = th;
        bus.t_low     = tl;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b1;
        bus8.start = 1'b1;
        tick();
        tick();
        checks++; if (bus.level !== 16'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", bus.phase); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus8.level !== 8'd0) begin errors++; $display("FAIL reset_level8: got %0d expected 0", bus8.level); end
        checks++; if (bus8.phase !== 3'd0) begin errors++; $display("FAIL reset_phase8: got %0d expected 0", bus8.phase); end
        rst = 1'b0;
        bus.start = 1'b0;
        bus8.start = 1'b0;
        tick();
    endtask

`ifndef PULSE_SEQ_REPEAT_EN
    task automatic test_single_shot;
        logic [15:0] lv [12];
        logic [2:0]  ph [12];
        lv = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd25, 16'd50, 16'd75, 16'd100, 16'd100, 16'd100, 16'd50, 16'd0};
        ph = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd0};
        set_cfg(16'd0, 16'd100, 16'd25, 16'd50, 16'd3, 16'd2, 16'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++; if (bus.level !== lv[i]) begin errors++; $display("FAIL single_level[%0d]: got %0d expected %0d", i, bus.level, lv[i]); end
            checks++; if (bus.phase !== ph[i]) begin errors++; $display("FAIL single_phase[%0d]: got %0d expected %0d", i, bus.phase, ph[i]); end
            checks++; if (bus.done !== (i == 11)) begin errors++; $display("FAIL single_done[%0d]: got %b expected %b", i, bus.done, (i == 11)); end
            checks++; if (bus.busy !== (i != 11)) begin errors++; $display("FAIL single_busy[%0d]: got %b expected %b", i, bus.busy, (i != 11)); end
            // Config changes and a stray start while busy must not disturb the run.
            if (i == 1) begin bus.pv = 16'd50; bus.t_high = 16'd7; bus.rise_step = 16'd1; end
            if (i == 5) bus.start = 1'b1;
            if (i == 6) bus.start = 1'b0;
            if (i < 11) tick();
        end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b expected 0", bus.done); end
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL single_idle_hold: got %0d expected 0", bus.phase); end
    endtask

    task automatic test_zero_durations;
        set_cfg(16'd10, 16'd20, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.phase !== 3'd2) begin errors++; $display("FAIL zero_rise_phase: got %0d expected 2", bus.phase); end
        checks++; if (bus.level !== 16'd10) begin errors++; $display("FAIL zero_rise_level: got %0d expected 10", bus.level); end
        tick();
        checks++; if (bus.phase !== 3'd4) begin errors++; $display("FAIL zero_fall_phase: got %0d expected 4", bus.phase); end
        checks++; if (bus.level !== 16'd20) begin errors++; $display("FAIL zero_fall_level: got %0d expected 20", bus.level); end
        tick();
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL zero_idle_phase: got %0d expected 0", bus.phase); end
        checks++; if (bus.level !== 16'd10) begin errors++; $display("FAIL zero_idle_level: got %0d expected 10", bus.level); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", bus.done); end
        tick();
    endtask
`else
    task automatic test_repeat;
        logic [15:0] lv [8];
        logic [2:0]  ph [8];
        lv = '{16'd0, 16'd10, 16'd20, 16'd30, 16'd30, 16'd15, 16'd0, 16'd0};
        ph = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5};
        set_cfg(16'd0, 16'd30, 16'd10, 16'd15, 16'd0, 16'd1, 16'd2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            checks++; if (bus.level !== lv[i % 8]) begin errors++; $display("FAIL repeat_level[%0d]: got %0d expected %0d", i, bus.level, lv[i % 8]); end
            checks++; if (bus.phase !== ph[i % 8]) begin errors++; $display("FAIL repeat_phase[%0d]: got %0d expected %0d", i, bus.phase, ph[i % 8]); end
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL repeat_done[%0d]: got %b expected 0", i, bus.done); end
            tick();
        end
        checks++; if (bus.phase !== 3'd2) begin errors++; $display("FAIL repeat_restart: got %0d expected 2", bus.phase); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL repeat_stop_busy: got %b expected 0", bus.busy); end
        tick();
    endtask
`endif

    task automatic test_abort;
        set_cfg(16'd5, 16'd40, 16'd0, 16'd0, 16'd1, 16'd5, 16'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.phase !== 3'd1) begin errors++; $display("FAIL abort_delay_phase: got %0d expected 1", bus.phase); end
        tick();
        checks++; if (bus.phase !== 3'd2) begin errors++; $display("FAIL abort_rise_phase: got %0d expected 2", bus.phase); end
        tick();
        checks++; if (bus.level !== 16'd40) begin errors++; $display("FAIL abort_high_level: got %0d expected 40", bus.level); end
        tick();
        checks++; if (bus.phase !== 3'd3) begin errors++; $display("FAIL abort_high_phase: got %0d expected 3", bus.phase); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL abort_phase: got %0d expected 0", bus.phase); end
        checks++; if (bus.level !== 16'd5) begin errors++; $display("FAIL abort_level: got %0d expected 5", bus.level); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bus.done); end
        // start and stop together in IDLE: stop wins.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL startstop_phase: got %0d expected 0", bus.phase); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL startstop_busy: got %b expected 0", bus.busy); end
        tick();
    endtask

    task automatic test_overflow;
        bus8.iv        = 8'd0;
        bus8.pv        = 8'd255;
        bus8.rise_step = 8'd200;
        bus8.fall_step = 8'd0;
        bus8.t_delay   = 8'd0;
        bus8.t_high    = 8'd0;
        bus8.t_low     = 8'd0;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        checks++; if (bus8.level !== 8'd0) begin errors++; $display("FAIL ovf_start_level: got %0d expected 0", bus8.level); end
        tick();
        checks++; if (bus8.level !== 8'd200) begin errors++; $display("FAIL ovf_step1: got %0d expected 200", bus8.level); end
        tick();
        checks++; if (bus8.level !== 8'd255) begin errors++; $display("FAIL ovf_step2: got %0d expected 255", bus8.level); end
        checks++; if (bus8.phase !== 3'd4) begin errors++; $display("FAIL ovf_phase: got %0d expected 4", bus8.phase); end
        bus8.stop = 1'b1;
        tick();
        bus8.stop = 1'b0;
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL ovf_stop_busy: got %b expected 0", bus8.busy); end
        tick();
    endtask

    task automatic test_reset_mid_rise;
        set_cfg(16'd7, 16'd100, 16'd10, 16'd0, 16'd0, 16'd1, 16'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++; if (bus.level !== 16'd17) begin errors++; $display("FAIL rstrise_pre_level: got %0d expected 17", bus.level); end
        rst = 1'b1;
        bus.start = 1'b1;
        tick();
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL rstrise_phase: got %0d expected 0", bus.phase); end
        checks++; if (bus.level !== 16'd0) begin errors++; $display("FAIL rstrise_level: got %0d expected 0", bus.level); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstrise_busy: got %b expected 0", bus.busy); end
        rst = 1'b0;
        bus.start = 1'b0;
        tick();
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL rstrise_no_restart: got %0d expected 0", bus.phase); end
        checks++; if (bus.level !== 16'd0) begin errors++; $display("FAIL rstrise_hold_level: got %0d expected 0", bus.level); end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_cfg(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        bus8.start     = 1'b0;
        bus8.stop      = 1'b0;
        bus8.iv        = 8'd0;
        bus8.pv        = 8'd0;
        bus8.rise_step = 8'd0;
        bus8.fall_step = 8'd0;
        bus8.t_delay   = 8'd0;
        bus8.t_high    = 8'd0;
        bus8.t_low     = 8'd0;

        test_reset();
`ifndef PULSE_SEQ_REPEAT_EN
        test_single_shot();
        test_zero_durations();
`else
        test_repeat();
`endif
        test_abort();
        test_overflow();
        test_reset_mid_rise();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
